// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 transmitter.
// Latency: pure wiring, no storage.
// Backpressure: tx_busy high means a tx_start pulse would be ignored.
//
// Signals:
//   tx_data  - command byte, sampled when tx_start is accepted
//   tx_start - one-cycle send request
//   tx_busy  - frame in progress, through the done/err cycle
//   tx_done  - one-cycle pulse, frame acked and bus idle
//   tx_err   - one-cycle pulse, no ack or timeout
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data + parity + stop, check ack.
// Latency: INHIBIT_CYCLES + 1 cycles to release the clock, then paced by the device clock.
// Backpressure: tx_start accepted only in IDLE; otherwise ignored while tx_busy is high.
//
// Ports:
//   clock            - system clock
//   resetn           - synchronous reset, active high
//   ps2c_in/ps2d_in  - raw PS/2 clock/data line levels
//   ps2c_oe/ps2d_oe  - 1 pulls the line low, 0 releases it (open drain)
//   host             - command handshake (tx_data/tx_start in, tx_busy/tx_done/tx_err out)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          ps2c_in,
    input  logic          ps2d_in,
    output logic          ps2c_oe,
    output logic          ps2d_oe,
    ps2_host_tx_if.slave  host
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    // ---------------------------------------------------------------
    // Input conditioning. Index 0 is the clock line, index 1 the data line.
    // A filtered value only flips after FILTER_LEN consecutive synchronized
    // samples disagree with it, so shorter glitches never reach the FSM.
    // ---------------------------------------------------------------
    logic [1:0]    sync1, sync2, filt;
    logic [FW-1:0] fcnt [2];
    logic          filt_c_d;
    logic          fall;

    always_ff @(posedge clock) begin
        if (resetn) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            filt     <= 2'b11;
            filt_c_d <= 1'b1;
            fcnt[0]  <= '0;
            fcnt[1]  <= '0;
        end else begin
            sync1    <= {ps2d_in, ps2c_in};
            sync2    <= sync1;
            filt_c_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    assign fall = filt_c_d & ~filt[0];

    // ---------------------------------------------------------------
    // FSM and datapath
    // ---------------------------------------------------------------
    state_t        state, state_nxt;
    logic [7:0]    data_q;
    logic          par_q;
    logic          d_q;      // data level to drive during SHIFT (1 = pull low)
    logic [3:0]    n_q;      // falls seen so far in SHIFT
    logic [CW-1:0] cnt_q;    // inhibit length, then reused as the timeout counter
    logic          timeout;
    logic          inhibit_end;

    assign timeout     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign inhibit_end = (cnt_q == CW'(INHIBIT_CYCLES - 1));

    // State register
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; timeout wins over a simultaneous fall
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (host.tx_start) state_nxt = S_INHIBIT;
            S_INHIBIT:   if (inhibit_end)   state_nxt = S_REQ;
            S_REQ:       state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (timeout)                       state_nxt = S_ERR;
                else if (fall && n_q == 4'd9)      state_nxt = S_ACK;
            end
            S_ACK: begin
                if (timeout)                       state_nxt = S_ERR;
                else if (fall)                     state_nxt = filt[1] ? S_ERR : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (timeout)                       state_nxt = S_ERR;
                else if (filt == 2'b11)            state_nxt = S_DONE;
            end
            S_DONE:      state_nxt = S_IDLE;
            S_ERR:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ps2c_oe      = (state == S_INHIBIT) || (state == S_REQ);
        ps2d_oe      = (state == S_REQ) || ((state == S_SHIFT) && d_q);
        host.tx_busy = (state != S_IDLE);
        host.tx_done = (state == S_DONE);
        host.tx_err  = (state == S_ERR);
    end

    // Datapath: latched byte, parity, bit counter, shared cycle counter
    always_ff @(posedge clock) begin
        if (resetn) begin
            data_q <= '0;
            par_q  <= 1'b0;
            d_q    <= 1'b0;
            n_q    <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.tx_start) begin
                        data_q <= host.tx_data;
                        par_q  <= ~^host.tx_data;
                        cnt_q  <= '0;
                    end
                end
                S_INHIBIT: cnt_q <= cnt_q + CW'(1);
                S_REQ: begin
                    // Start bit stays on the data line once the clock is released
                    cnt_q <= '0;
                    n_q   <= '0;
                    d_q   <= 1'b1;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (fall && !timeout) begin
                        n_q <= n_q + 4'd1;
                        if (n_q < 4'd8)       d_q <= ~data_q[n_q[2:0]];
                        else if (n_q == 4'd8) d_q <= ~par_q;
                        else                  d_q <= 1'b0;
                    end
                end
                S_ACK, S_WAIT_IDLE: cnt_q <= cnt_q + CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-drain lines.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int FLT = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    logic dev_c  = 1'b1;
    logic dev_d  = 1'b1;
    logic ps2c_oe, ps2d_oe;
    logic ps2c_line, ps2d_line;

    ps2_host_tx_if host_if ();

    assign ps2c_line = ~ps2c_oe & dev_c;
    assign ps2d_line = ~ps2d_oe & dev_d;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .ps2c_in (ps2c_line),
        .ps2d_in (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .host    (host_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Pulse monitor
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic       done_d   = 1'b0;
    logic       busy_after_done = 1'bx;
    logic [1:0] err_oe   = 2'bxx;

    always @(negedge clock) begin
        if (host_if.tx_done) done_cnt++;
        if (host_if.tx_err) begin
            err_cnt++;
            err_oe = {ps2c_oe, ps2d_oe};
        end
        if (done_d) busy_after_done = host_if.tx_busy;
        done_d = host_if.tx_done;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Issue a request and measure inhibit / start-bit lengths; returns at clock release.
    task automatic start_frame(input logic [7:0] d, output int inh, output int st, output logic busy0);
        @(negedge clock);
        host_if.tx_data  = d;
        host_if.tx_start = 1'b1;
        @(negedge clock);
        host_if.tx_start = 1'b0;
        busy0 = host_if.tx_busy;
        inh = 0;
        while (ps2c_oe && !ps2d_oe && inh < 1000) begin
            inh++;
            @(negedge clock);
        end
        st = 0;
        while (ps2c_oe && ps2d_oe && st < 100) begin
            st++;
            @(negedge clock);
        end
    endtask

    // Keyboard model: 40-cycle half periods, samples data on its rising edges.
    task automatic device_frame(input bit ack, input int stop_at, input int glitch_k,
                                output logic [9:0] bits, output logic start_bit);
        bits = '0;
        start_bit = ps2d_line;
        repeat (40) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            dev_c = 1'b0;
            if (k == stop_at) return;
            repeat (40) @(negedge clock);
            dev_c = 1'b1;
            if (k <= 10) bits[k-1] = ps2d_line;
            if (k == 11) dev_d = 1'b1;
            repeat (20) @(negedge clock);
            if (k == 10 && ack) dev_d = 1'b0;
            if (k == glitch_k) begin
                dev_c = 1'b0;
                @(negedge clock);
                dev_c = 1'b1;
                repeat (19) @(negedge clock);
            end else begin
                repeat (20) @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        host_if.tx_start = 1'b0;
        host_if.tx_data  = 8'h00;
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (ps2c_oe !== 1'b0) $display("FAIL reset_ps2c_oe got %b want 0", ps2c_oe); else passed++;
        checks++; if (ps2d_oe !== 1'b0) $display("FAIL reset_ps2d_oe got %b want 0", ps2d_oe); else passed++;
        checks++; if (host_if.tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", host_if.tx_busy); else passed++;
        checks++; if (host_if.tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", host_if.tx_done); else passed++;
        checks++; if (host_if.tx_err !== 1'b0) $display("FAIL reset_err got %b want 0", host_if.tx_err); else passed++;
        resetn = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_send_f4();
        int inh, st, d0, e0;
        logic busy0, sb;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hF4, inh, st, busy0);
        checks++; if (busy0 !== 1'b1) $display("FAIL f4_busy_after_accept got %b want 1", busy0); else passed++;
        checks++; if (inh != 20) $display("FAIL f4_inhibit_len got %0d want 20", inh); else passed++;
        checks++; if (st != 1) $display("FAIL f4_start_len got %0d want 1", st); else passed++;
        checks++; if (ps2d_oe !== 1'b1) $display("FAIL f4_data_held_after_release got %b want 1", ps2d_oe); else passed++;
        device_frame(1'b1, 0, 0, bits, sb);
        checks++; if (sb !== 1'b0) $display("FAIL f4_start_bit got %b want 0", sb); else passed++;
        checks++; if (bits !== 10'h2F4) $display("FAIL f4_bits got %h want 2f4", bits); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL f4_done_count got %0d want 1", done_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 != 0) $display("FAIL f4_err_count got %0d want 0", err_cnt - e0); else passed++;
        checks++; if (busy_after_done !== 1'b0) $display("FAIL f4_busy_after_done got %b want 0", busy_after_done); else passed++;
    endtask

    task automatic test_send_ed();
        int inh, st, d0, e0;
        logic busy0, sb;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hED, inh, st, busy0);
        device_frame(1'b1, 0, 0, bits, sb);
        checks++; if (bits !== 10'h3ED) $display("FAIL ed_bits got %h want 3ed", bits); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL ed_done_count got %0d want 1", done_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 != 0) $display("FAIL ed_err_count got %0d want 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_no_ack();
        int inh, st, d0, e0;
        logic busy0, sb;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hF4, inh, st, busy0);
        device_frame(1'b0, 0, 0, bits, sb);
        checks++; if (err_cnt - e0 != 1) $display("FAIL noack_err_count got %0d want 1", err_cnt - e0); else passed++;
        checks++; if (done_cnt - d0 != 0) $display("FAIL noack_done_count got %0d want 0", done_cnt - d0); else passed++;
        checks++; if (err_oe !== 2'b00) $display("FAIL noack_oe_at_err got %b want 00", err_oe); else passed++;
    endtask

    task automatic test_timeout();
        int inh, st, n;
        logic busy0;
        start_frame(8'hF4, inh, st, busy0);
        n = 0;
        while (!host_if.tx_err && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n != 2000) $display("FAIL timeout_cycles got %0d want 2000", n); else passed++;
        checks++; if ({ps2c_oe, ps2d_oe} !== 2'b00) $display("FAIL timeout_oe got %b want 00", {ps2c_oe, ps2d_oe}); else passed++;
        @(negedge clock);
        checks++; if (host_if.tx_busy !== 1'b0) $display("FAIL timeout_busy_after got %b want 0", host_if.tx_busy); else passed++;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_start_ignored();
        int inh, st, d0, hi;
        logic busy0, sb;
        logic [9:0] bits;
        d0 = done_cnt;
        start_frame(8'hF4, inh, st, busy0);
        fork
            device_frame(1'b1, 0, 0, bits, sb);
            begin
                repeat (200) @(negedge clock);
                host_if.tx_data  = 8'hFF;
                host_if.tx_start = 1'b1;
                @(negedge clock);
                host_if.tx_start = 1'b0;
            end
        join
        checks++; if (bits !== 10'h2F4) $display("FAIL ignore_bits got %h want 2f4", bits); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL ignore_done_count got %0d want 1", done_cnt - d0); else passed++;
        hi = 0;
        repeat (100) begin
            @(negedge clock);
            if (ps2c_oe) hi++;
        end
        checks++; if (hi != 0) $display("FAIL ignore_no_restart got %0d want 0", hi); else passed++;
    endtask

    task automatic test_reset_glitch();
        int inh, st, d0, e0;
        logic busy0, sb;
        logic [9:0] bits;
        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'hED, inh, st, busy0);
        device_frame(1'b1, 5, 0, bits, sb);
        repeat (8) @(negedge clock);
        resetn = 1'b1;
        dev_c  = 1'b1;
        @(negedge clock);
        checks++; if (ps2c_oe !== 1'b0) $display("FAIL midreset_ps2c_oe got %b want 0", ps2c_oe); else passed++;
        checks++; if (ps2d_oe !== 1'b0) $display("FAIL midreset_ps2d_oe got %b want 0", ps2d_oe); else passed++;
        checks++; if (host_if.tx_busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", host_if.tx_busy); else passed++;
        resetn = 1'b0;
        repeat (50) @(negedge clock);
        checks++; if ((done_cnt - d0) + (err_cnt - e0) != 0)
            $display("FAIL midreset_pulses got %0d want 0", (done_cnt - d0) + (err_cnt - e0)); else passed++;

        d0 = done_cnt; e0 = err_cnt;
        start_frame(8'h5A, inh, st, busy0);
        device_frame(1'b1, 0, 3, bits, sb);
        checks++; if (bits !== 10'h35A) $display("FAIL glitch_bits got %h want 35a", bits); else passed++;
        checks++; if (done_cnt - d0 != 1) $display("FAIL glitch_done_count got %0d want 1", done_cnt - d0); else passed++;
        checks++; if (err_cnt - e0 != 0) $display("FAIL glitch_err_count got %0d want 0", err_cnt - e0); else passed++;
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_send_ed();
        test_no_ack();
        test_timeout();
        test_start_ignored();
        test_reset_glitch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
